ps2_key_receiver: RTL and testbench



---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_frame_rx.sv | 100 ++++++++++
 rtl/ps2_key_receiver.sv | 77 +++++++
 tb/tb_ps2_key_receiver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and protocol constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] PS2_KEY_NONE   = 8'h00;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserializer: pin synchronizers, falling-edge detect, frame FSM, timeout.
// Odd-parity checking is built only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC - 1);

  ps2_state_e state, state_nxt;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_dly;
  logic                   clk_s, dat_s, fall;
  logic [2:0]             bit_cnt;
  logic [15:0]            tcnt;
  logic                   timeout, stop_done, par_ok;

  // Synchronizers reset to the idle-high line level so reset release never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_dly  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_dly  <= clk_s;
    end
  end

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign dat_s   = dat_sync[SYNC_STAGES-1];
  assign fall    = clk_dly & ~clk_s;
  assign timeout = (state != IDLE) && (tcnt == TO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) state_nxt = IDLE;
    else if (fall) begin
      unique case (state)
        IDLE:    if (!dat_s) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      par_bit <= 1'b0;
    else if (state == PARITY && fall) par_bit <= dat_s;
  end
  assign par_ok = ^{rx_byte, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    stop_done  = (state == STOP) && fall && !timeout;
    byte_valid = stop_done && dat_s && par_ok;
    err        = timeout || (stop_done && !(dat_s && par_ok));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte <= '0;
      bit_cnt <= '0;
      tcnt    <= '0;
    end else begin
      tcnt <= (fall || state == IDLE) ? 16'd0 : tcnt + 16'd1;
      if (fall) begin
        if (state == IDLE) bit_cnt <= '0;
        if (state == DATA) begin
          rx_byte <= {dat_s, rx_byte[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frame RX plus E0/F0 prefix decode and held-key tracking.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_key_valid,
  output logic [7:0] o_key_code,
  output logic       o_key_ext,
  output logic       o_key_break,
  output logic [7:0] o_key_held,
  output logic       o_frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid, rx_err;
  logic       ext_flag, brk_flag, held_ext;

  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .ps2_clk    (i_ps2_clk),
    .ps2_dat    (i_ps2_dat),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .err        (rx_err)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_key_valid <= 1'b0;
      o_key_code  <= '0;
      o_key_ext   <= 1'b0;
      o_key_break <= 1'b0;
      o_key_held  <= PS2_KEY_NONE;
      o_frame_err <= 1'b0;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      held_ext    <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      o_frame_err <= rx_err;
      if (rx_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == PS2_PREFIX_EXT)      ext_flag <= 1'b1;
        else if (rx_byte == PS2_PREFIX_BRK) brk_flag <= 1'b1;
        else begin
          o_key_valid <= 1'b1;
          o_key_code  <= rx_byte;
          o_key_ext   <= ext_flag;
          o_key_break <= brk_flag;
          ext_flag    <= 1'b0;
          brk_flag    <= 1'b0;
          // A release only drops the held key if it names the same (code, ext) pair
          if (!brk_flag) begin
            o_key_held <= rx_byte;
            held_ext   <= ext_flag;
          end else if (o_key_held == rx_byte && held_ext == ext_flag) begin
            o_key_held <= PS2_KEY_NONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: directed PS/2 frames, monitor pops expected events.
module tb_ps2_key_receiver;

  localparam int H       = 20;
  localparam int TIMEOUT = 50000;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_ps2_clk = 1'b1;
  logic       i_ps2_dat = 1'b1;
  logic       o_key_valid, o_key_ext, o_key_break, o_frame_err;
  logic [7:0] o_key_code, o_key_held;

  ps2_key_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYC(TIMEOUT)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_dat   (i_ps2_dat),
    .o_key_valid (o_key_valid),
    .o_key_code  (o_key_code),
    .o_key_ext   (o_key_ext),
    .o_key_break (o_key_break),
    .o_key_held  (o_key_held),
    .o_frame_err (o_frame_err)
  );

  always #20 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] held;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0, err_seen = 0, err_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk,
                           input logic [7:0] held);
    exp_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.held = held;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    i_ps2_dat = b;
    repeat (H) @(negedge i_clk);
    i_ps2_clk = 1'b0;
    repeat (H) @(negedge i_clk);
    i_ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic par, input logic stp);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stp);
    i_ps2_dat = 1'b1;
    repeat (4 * H) @(negedge i_clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(o_key_valid), 0);
    check({tag, "_code"},  32'(o_key_code),  0);
    check({tag, "_ext"},   32'(o_key_ext),   0);
    check({tag, "_break"}, 32'(o_key_break), 0);
    check({tag, "_held"},  32'(o_key_held),  0);
    check({tag, "_err"},   32'(o_frame_err), 0);
  endtask

  // Monitor: every strobe must match the head of the expected queue
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_frame_err) err_seen++;
        if (o_key_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_event: got code %0h ext %0b brk %0b, expected no event",
                     o_key_code, o_key_ext, o_key_break);
          end else begin
            mon_e = exp_q.pop_front();
            check("ev_code",  32'(o_key_code),  32'(mon_e.code));
            check("ev_ext",   32'(o_key_ext),   32'(mon_e.ext));
            check("ev_break", 32'(o_key_break), 32'(mon_e.brk));
            check("ev_held",  32'(o_key_held),  32'(mon_e.held));
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge i_clk);
    check_outputs_zero("reset");
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);

    // Plain make
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h1C);
    send(8'h1C, 1'b0, 1'b1);
    check("make_1c_drained", exp_q.size(), 0);

    // Break of held key
    expect_ev(8'h1C, 1'b0, 1'b1, 8'h00);
    send(8'hF0, 1'b1, 1'b1);
    send(8'h1C, 1'b0, 1'b1);
    check("break_1c_drained", exp_q.size(), 0);

    // Extended make and extended break
    expect_ev(8'h75, 1'b1, 1'b0, 8'h75);
    send(8'hE0, 1'b0, 1'b1);
    send(8'h75, 1'b0, 1'b1);
    expect_ev(8'h75, 1'b1, 1'b1, 8'h00);
    send(8'hE0, 1'b0, 1'b1);
    send(8'hF0, 1'b1, 1'b1);
    send(8'h75, 1'b0, 1'b1);
    check("ext_drained", exp_q.size(), 0);

    // Non-extended break must not release an extended held key
    expect_ev(8'h75, 1'b1, 1'b0, 8'h75);
    send(8'hE0, 1'b0, 1'b1);
    send(8'h75, 1'b0, 1'b1);
    expect_ev(8'h75, 1'b0, 1'b1, 8'h75);
    send(8'hF0, 1'b1, 1'b1);
    send(8'h75, 1'b0, 1'b1);
    check("ext_mismatch_held", 32'(o_key_held), 32'h75);

    // Bad stop bit
    err_exp++;
    send(8'h1C, 1'b0, 1'b0);
    check("stop_err_count", err_seen, err_exp);
    check("stop_err_held", 32'(o_key_held), 32'h75);
    expect_ev(8'h29, 1'b0, 1'b0, 8'h29);
    send(8'h29, 1'b0, 1'b1);
    expect_ev(8'h29, 1'b0, 1'b0, 8'h29);
    send(8'h29, 1'b0, 1'b1);
    check("typematic_drained", exp_q.size(), 0);

    // Timeout after E0 prefix and 4 data bits; prefix must be discarded
    send(8'hE0, 1'b0, 1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    i_ps2_dat = 1'b1;
    repeat (TIMEOUT - 1000) @(negedge i_clk);
    check("timeout_not_early", err_seen, err_exp);
    err_exp++;
    repeat (1200) @(negedge i_clk);
    check("timeout_once", err_seen, err_exp);
    check("timeout_held", 32'(o_key_held), 32'h29);
    expect_ev(8'h29, 1'b0, 1'b0, 8'h29);
    send(8'h29, 1'b0, 1'b1);
    check("after_timeout_drained", exp_q.size(), 0);

    // Wrong parity bit
`ifdef PS2_PARITY_CHECK_EN
    err_exp++;
`else
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h1C);
`endif
    send(8'h1C, 1'b1, 1'b1);
    check("parity_err_count", err_seen, err_exp);
    check("parity_drained", exp_q.size(), 0);

    // Reset mid-frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check_outputs_zero("midreset");
    i_ps2_dat = 1'b1;
    repeat (5) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (4 * H) @(negedge i_clk);
    check("midreset_no_err", err_seen, err_exp);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h1C);
    send(8'h1C, 1'b0, 1'b1);
    check("final_drained", exp_q.size(), 0);
    check("final_err_count", err_seen, err_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
